// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// Optional operand/result reuse is enabled by defining MULDIV_REUSE_EN.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state_reg, state_next;

  logic [2:0]        op_reg;
  logic [4:0]        rd_reg;
  logic              neg_reg;      // product / quotient sign
  logic              rem_neg_reg;  // remainder follows the dividend
  logic [XLEN-1:0]   opnd_reg;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              special_reg;
  logic [XLEN-1:0]   special_val_reg;
  logic [XLEN-1:0]   result_hold_reg;
  logic [4:0]        rd_hold_reg;

  logic            accept;
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special_in;
  logic [XLEN-1:0] special_val_in;

  assign accept   = (state_reg == IDLE) && req_i && !flush_i;
  assign a_signed = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'b11);
  assign b_signed = op_i[2] ? !op_i[0] : !op_i[1];
  assign a_neg    = a_signed && rs1_i[XLEN-1];
  assign b_neg    = b_signed && rs2_i[XLEN-1];
  assign a_mag    = a_neg ? -rs1_i : rs1_i;
  assign b_mag    = b_neg ? -rs2_i : rs2_i;
  assign div_zero = op_i[2] && (rs2_i == '0);
  assign div_ovf  = op_i[2] && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);

  // Iteration datapaths; the accumulator holds {hi, lo} for both ops.
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  assign acc_hi    = acc_reg[2*XLEN-1:XLEN];
  assign acc_lo    = acc_reg[XLEN-1:0];
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
  assign mul_next  = {mul_sum, acc_lo[XLEN-1:1]};
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_reg};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_result;

  assign prod_fix = neg_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_reg ? -acc_lo : acc_lo;
  assign rem_fix  = rem_neg_reg ? -acc_hi : acc_hi;

  always_comb begin
    fin_result = special_val_reg;
    if (!special_reg) begin
      if (op_reg[2])
        fin_result = op_reg[1] ? rem_fix : quo_fix;
      else
        fin_result = (op_reg[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

`ifdef MULDIV_REUSE_EN
  logic              reuse_valid_reg, reuse_mul_reg;
  logic [2:0]        reuse_op_reg;
  logic [XLEN-1:0]   reuse_rs1_reg, reuse_rs2_reg, reuse_res_reg;
  logic [XLEN-1:0]   lat_rs1_reg, lat_rs2_reg;
  logic [2*XLEN-1:0] reuse_prod_reg;
  logic              same_opnds, hit_exact, hit_half;

  // MUL shares its signedness class with MULH.
  function automatic logic [1:0] sgn_cls(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 2'b01 : op[1:0];
  endfunction

  assign same_opnds = reuse_valid_reg && (rs1_i == reuse_rs1_reg) && (rs2_i == reuse_rs2_reg);
  assign hit_exact  = same_opnds && (op_i == reuse_op_reg);
  assign hit_half   = same_opnds && reuse_mul_reg && !op_i[2]
                      && (sgn_cls(op_i) == sgn_cls(reuse_op_reg));

  always_comb begin
    special_in     = div_zero || div_ovf || hit_exact || hit_half;
    special_val_in = '0;
    if (div_zero)
      special_val_in = op_i[1] ? rs1_i : '1;
    else if (div_ovf)
      special_val_in = op_i[1] ? '0 : rs1_i;
    else if (hit_exact)
      special_val_in = reuse_res_reg;
    else if (op_i[1:0] == 2'b00)
      special_val_in = reuse_prod_reg[XLEN-1:0];
    else
      special_val_in = reuse_prod_reg[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reuse_valid_reg <= 1'b0;
      reuse_mul_reg   <= 1'b0;
      reuse_op_reg    <= '0;
      reuse_rs1_reg   <= '0;
      reuse_rs2_reg   <= '0;
      reuse_res_reg   <= '0;
      reuse_prod_reg  <= '0;
      lat_rs1_reg     <= '0;
      lat_rs2_reg     <= '0;
    end else begin
      if (accept) begin
        lat_rs1_reg <= rs1_i;
        lat_rs2_reg <= rs2_i;
      end
      if (done_o) begin
        reuse_valid_reg <= 1'b1;
        reuse_op_reg    <= op_reg;
        reuse_rs1_reg   <= lat_rs1_reg;
        reuse_rs2_reg   <= lat_rs2_reg;
        reuse_res_reg   <= fin_result;
        // A reuse hit on a multiply leaves the stored product valid.
        if (!special_reg) begin
          reuse_prod_reg <= prod_fix;
          reuse_mul_reg  <= !op_reg[2];
        end else if (op_reg[2]) begin
          reuse_mul_reg <= 1'b0;
        end
      end
      if (flush_i)
        reuse_valid_reg <= 1'b0;
    end
  end
`else
  always_comb begin
    special_in     = div_zero || div_ovf;
    special_val_in = '0;
    if (div_zero)
      special_val_in = op_i[1] ? rs1_i : '1;
    else if (div_ovf)
      special_val_in = op_i[1] ? '0 : rs1_i;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = special_in ? FIN : CALC;
      CALC: begin
        if (flush_i)
          state_next = IDLE;
        else if (cnt_reg == CNT_W'(XLEN-1))
          state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      op_reg          <= '0;
      rd_reg          <= '0;
      neg_reg         <= 1'b0;
      rem_neg_reg     <= 1'b0;
      opnd_reg        <= '0;
      acc_reg         <= '0;
      cnt_reg         <= '0;
      special_reg     <= 1'b0;
      special_val_reg <= '0;
      result_hold_reg <= '0;
      rd_hold_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg          <= op_i;
        rd_reg          <= rd_i;
        neg_reg         <= a_neg ^ b_neg;
        rem_neg_reg     <= a_neg;
        opnd_reg        <= op_i[2] ? b_mag : a_mag;
        acc_reg         <= {{XLEN{1'b0}}, (op_i[2] ? a_mag : b_mag)};
        cnt_reg         <= '0;
        special_reg     <= special_in;
        special_val_reg <= special_val_in;
      end else if (state_reg == CALC) begin
        acc_reg <= op_reg[2] ? div_next : mul_next;
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (done_o) begin
        result_hold_reg <= fin_result;
        rd_hold_reg     <= rd_reg;
      end
    end
  end

  assign busy_o   = (state_reg != IDLE);
  assign stall_o  = rst_n && (accept || (state_reg == CALC));
  assign done_o   = rst_n && (state_reg == FIN) && !flush_i;
  assign result_o = done_o ? fin_result : result_hold_reg;
  assign rd_o     = done_o ? rd_reg : rd_hold_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: latency, results, special cases, flush, reset abort.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        flush_i = 1'b0;
  logic        stall_o, done_o, busy_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_fail = 0;

`ifdef MULDIV_REUSE_EN
  localparam int REUSE_LAT = 1;
`else
  localparam int REUSE_LAT = 33;
`endif

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_i(rd_i), .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the negedge after the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic stall_ok;
    lat = 0;
    stall_ok = 1'b1;
    req_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
    #1;
    check("stall_at_T", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1 req_i = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done_o) begin
        lat = c;
        break;
      end
      if (!stall_o) stall_ok = 1'b0;
    end
    $display("op=%0d rs1=%h rs2=%h rd=%0d result=%h lat=%0d", op, a, b, rd, result_o, lat);
    check("latency", 32'(lat), 32'(exp_lat));
    check("result", result_o, exp);
    check("rd", 32'(rd_o), 32'(rd));
    check("stall_held", 32'(stall_ok), 32'd1);
    check("stall_done", 32'(stall_o), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done_o), 32'd0);
  endtask

  initial begin
    logic saw_done;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", 32'(rd_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 33);         // MUL 7*-3
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFE, 33);  // MULHU
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'h00000000, 33);  // MULH
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, 5'd6, 32'hFFFFFFFF, 33);         // MULHSU -2*3
    run_op(3'd4, 32'hFFFFFFEC, 32'd6, 5'd7, 32'hFFFFFFFD, 33);         // DIV -20/6
    run_op(3'd6, 32'hFFFFFFEC, 32'd6, 5'd8, 32'hFFFFFFFE, 33);         // REM -20/6
    run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 33);                    // DIVU
    run_op(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 33);                    // REMU
    run_op(3'd5, 32'h1234, 32'd0, 5'd11, 32'hFFFFFFFF, 1);             // DIVU /0
    run_op(3'd7, 32'h1234, 32'd0, 5'd12, 32'h1234, 1);                 // REMU /0
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 1);         // REM overflow
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);  // DIV overflow

    // Flush a divide at T+10; the next multiply is accepted at T+11.
    saw_done = 1'b0;
    req_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd7; rd_i = 5'd15;
    @(posedge clk);
    #1 req_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
      if (c == 10) flush_i = 1'b1;
    end
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    $display("flush: busy=%0d done=%0d", busy_o, done_o);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_done", 32'(saw_done || done_o), 32'd0);
    run_op(3'd0, 32'd12, 32'd11, 5'd16, 32'd132, 33);

    // Reset mid-operation aborts silently.
    saw_done = 1'b0;
    req_i = 1'b1; op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd17;
    @(posedge clk);
    #1 req_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset abort: busy=%0d result=%h", busy_o, result_o);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_result", result_o, 32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);

    run_op(3'd1, 32'd3, 32'd5, 5'd18, 32'd0, 33);                      // MULH 3,5
    run_op(3'd0, 32'd3, 32'd5, 5'd19, 32'd15, REUSE_LAT);              // MUL 3,5

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
